// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encodings and constants for the instruction fetch controller
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } fetch_state_t;

    localparam logic [15:0] PC_STEP          = 16'd2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_ctrl_add16.sv
// rtl/fetch_ctrl_add16.sv - 16-bit adder with carry in/out
module fetch_ctrl_add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    // plain ripple-style add; carry out is available but wrap is modulo 2^16
    assign {cout_o, sum_o} = a_i + b_i + {15'd0, cin_i};

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller; optional request timeout via FETCH_CTRL_TIMEOUT_EN
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc2,
    output logic        err
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  pc2_q, pc2_d;
    logic         valid_q, valid_d;
    logic [15:0]  pc_plus2;
    logic         unused_cout;
    logic         capture;

`ifdef FETCH_CTRL_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT4 = 4'(TIMEOUT);
    logic [3:0] cnt_q, cnt_d;
`endif

    fetch_ctrl_add16 u_pc_add (
        .a_i    (pc_q),
        .b_i    (PC_STEP),
        .cin_i  (1'b0),
        .sum_o  (pc_plus2),
        .cout_o (unused_cout)
    );

    // request is dropped while reset is asserted so a pending read is abandoned
    assign mem_en      = !rst && (state_q == ST_RUN) && !(valid_q && stall);
    assign mem_addr    = pc_q;
    assign capture     = mem_en && mem_ready;
    assign instr       = instr_q;
    assign pc2         = pc2_q;
    assign instr_valid = valid_q && (state_q == ST_RUN);

`ifdef FETCH_CTRL_TIMEOUT_EN
    assign err = (state_q == ST_ERROR);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err            = 1'b0;
`endif

    // next-state: redirect beats halt, halt beats capture, capture beats consume
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
`ifdef FETCH_CTRL_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end else if (halt && valid_q && !stall) begin
                    state_d = ST_HALTED;
                    valid_d = 1'b0;
                end else begin
                    if (capture) begin
                        instr_d = mem_data;
                        valid_d = 1'b1;
                        pc2_d   = pc_plus2;
                        pc_d    = pc_plus2;
                    end else if (valid_q && !stall) begin
                        valid_d = 1'b0;
                    end
`ifdef FETCH_CTRL_TIMEOUT_EN
                    if (capture) begin
                        cnt_d = 4'd0;
                    end else if (mem_en && !mem_ready) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == TIMEOUT4) begin
                            state_d = ST_ERROR;
                            valid_d = 1'b0;
                        end
                    end
`endif
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // state registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            pc2_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_CTRL_TIMEOUT_EN
    // wait-cycle counter for the outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc2;
    logic        err;

    int n_vec;
    int n_miss;

    fetch_ctrl #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc2         (pc2),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one edge, then let the memory model return data for the new address
    task automatic cyc();
        @(posedge clk);
        #1;
        mem_data = mem_addr;
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        mem_ready   = 1'b1;
        mem_data    = 16'h0000;

        // reset state
        cyc();
        chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_pc2", pc2, 16'h0000);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'd0);

        // streaming fetch: instr 0,2,4,6 on consecutive cycles
        rst = 1'b0;
        #1;
        chk("run_mem_en", {15'd0, mem_en}, 16'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("stream_valid", {15'd0, instr_valid}, 16'd1);
            chk("stream_instr", instr, 16'(2 * k));
            chk("stream_pc2", pc2, 16'(2 * k + 2));
        end

        // stall holds instr 6 for three cycles
        stall = 1'b1;
        #1;
        chk("stall_mem_en0", {15'd0, mem_en}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_instr", instr, 16'h0006);
            chk("stall_pc2", pc2, 16'h0008);
            chk("stall_valid", {15'd0, instr_valid}, 16'd1);
            chk("stall_mem_en", {15'd0, mem_en}, 16'd0);
            chk("stall_addr", mem_addr, 16'h0008);
        end
        stall = 1'b0;
        cyc();
        chk("unstall_instr", instr, 16'h0008);
        chk("unstall_pc2", pc2, 16'h000A);

        // redirect drops the same-cycle capture
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        cyc();
        chk("redir_valid", {15'd0, instr_valid}, 16'd0);
        chk("redir_addr", mem_addr, 16'h1234);
        chk("redir_instr_kept", instr, 16'h0008);
        redirect = 1'b0;
        cyc();
        chk("redir_data", instr, 16'h1234);
        chk("redir_pc2", pc2, 16'h1236);
        chk("redir_dvalid", {15'd0, instr_valid}, 16'd1);

        // consume with no capture
        mem_ready = 1'b0;
        cyc();
        chk("consume_valid", {15'd0, instr_valid}, 16'd0);
        chk("consume_addr", mem_addr, 16'h1236);

        // pc wrap at 16'hFFFE
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        cyc();
        redirect  = 1'b0;
        mem_ready = 1'b1;
        cyc();
        chk("wrap_instr", instr, 16'hFFFE);
        chk("wrap_pc2", pc2, 16'h0000);
        chk("wrap_addr", mem_addr, 16'h0000);
        chk("wrap_err", {15'd0, err}, 16'd0);

        // memory never ready
        mem_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
`ifdef FETCH_CTRL_TIMEOUT_EN
            if (i == 14) chk("to_err_before", {15'd0, err}, 16'd0);
            if (i == 15) chk("to_err_set", {15'd0, err}, 16'd1);
            if (i == 20) begin
                chk("to_err_sticky", {15'd0, err}, 16'd1);
                chk("to_mem_en", {15'd0, mem_en}, 16'd0);
            end
`else
            if (i == 20) begin
                chk("noto_err", {15'd0, err}, 16'd0);
                chk("noto_mem_en", {15'd0, mem_en}, 16'd1);
            end
`endif
        end

        // reset mid-wait abandons the request
        rst = 1'b1;
        #1;
        chk("rstwait_mem_en", {15'd0, mem_en}, 16'd0);
        cyc();
        chk("rstwait_err", {15'd0, err}, 16'd0);
        rst       = 1'b0;
        mem_ready = 1'b1;
        cyc();
        chk("h_instr0", instr, 16'h0000);

        // halt ignored while stalled
        halt  = 1'b1;
        stall = 1'b1;
        cyc();
        chk("halt_stall_valid", {15'd0, instr_valid}, 16'd1);
        chk("halt_stall_instr", instr, 16'h0000);
        stall = 1'b0;
        cyc();
        chk("halted_valid", {15'd0, instr_valid}, 16'd0);
        halt        = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("halted_mem_en", {15'd0, mem_en}, 16'd0);
            chk("halted_valid2", {15'd0, instr_valid}, 16'd0);
        end
        chk("halted_addr", mem_addr, 16'h0002);
        redirect = 1'b0;

        // only reset leaves HALTED
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("resume_instr", instr, 16'h0000);
        chk("resume_valid", {15'd0, instr_valid}, 16'd1);
        chk("resume_addr", mem_addr, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
